// File: rtl/regdump_pkg.sv
// Shared types and sizing for the register-file dump reader.
package regdump_pkg;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD,
        DONE
    } state_e;
endpackage

// File: rtl/regfile_dump_reader_if.sv
// Output word stream of the dump reader: (addr, data) with valid/ready.
interface regfile_dump_reader_if #(
    parameter int unsigned ADDR_W = regdump_pkg::ADDR_W,
    parameter int unsigned DATA_W = regdump_pkg::DATA_W
) ();
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_addr, output out_data, input out_ready);
    modport slave  (input out_valid, input out_addr, input out_data, output out_ready);
endinterface

// File: rtl/regdump_shadow.sv
// Shadow copy of the register file with per-entry valid bits for changed-only dumps.
module regdump_shadow #(
    parameter int unsigned NUM_REGS = regdump_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = regdump_pkg::ADDR_W,
    parameter int unsigned DATA_W   = regdump_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);
    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] vld;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld <= '0;
        end else if (we) begin
            vld[waddr] <= 1'b1;
        end
    end

    // Data needs no reset: an entry is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata  = mem[raddr];
    assign rvalid = vld[raddr];
endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a register range through a spare read port and streams (addr, data) words out.
module regfile_dump_reader #(
    parameter int unsigned NUM_REGS = regdump_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = regdump_pkg::ADDR_W,
    parameter int unsigned DATA_W   = regdump_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     first_addr,
    input  logic [ADDR_W-1:0]     last_addr,
    input  logic                  changed_only,
    input  logic                  clear_shadow,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    regfile_dump_reader_if.master out_if,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       emit_count
);
    import regdump_pkg::*;

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] cur, cur_nxt, last_q, last_nxt;
    logic [ADDR_W:0]   cnt, cnt_nxt, emit_nxt;
    logic              chg_q, chg_nxt;
    logic              cap, sh_we, sh_clr, skip;
    logic [DATA_W-1:0] sh_data;
    logic              sh_valid;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;

    regdump_shadow #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) u_shadow (
        .clk   (clk),
        .rst   (rst),
        .clr   (sh_clr),
        .we    (sh_we),
        .waddr (cur),
        .wdata (rd_data),
        .raddr (cur),
        .rdata (sh_data),
        .rvalid(sh_valid)
    );

    assign skip = chg_q && sh_valid && (sh_data == rd_data);

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        cnt_nxt   = cnt;
        last_nxt  = last_q;
        chg_nxt   = chg_q;
        emit_nxt  = emit_count;
        cap       = 1'b0;
        sh_we     = 1'b0;
        sh_clr    = 1'b0;
        case (state)
            IDLE: begin
                sh_clr = clear_shadow;
                if (start) begin
                    cur_nxt  = first_addr;
                    cnt_nxt  = '0;
                    last_nxt = last_addr;
                    chg_nxt  = changed_only;
                    if (first_addr <= last_addr) begin
                        state_nxt = READ;
                    end else begin
                        state_nxt = DONE;
                        emit_nxt  = '0;
                    end
                end
            end
            READ: begin
                sh_we = 1'b1;
                if (!skip) begin
                    cap       = 1'b1;
                    state_nxt = HOLD;
                end else if (cur == last_q) begin
                    state_nxt = DONE;
                    emit_nxt  = cnt;
                end else begin
                    cur_nxt = cur + 1'b1;
                end
            end
            HOLD: begin
                if (out_if.out_ready) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cur == last_q) begin
                        state_nxt = DONE;
                        emit_nxt  = cnt + 1'b1;
                    end else begin
                        cur_nxt   = cur + 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything above, including a same-cycle handshake.
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            cur_nxt   = cur;
            cnt_nxt   = cnt;
            emit_nxt  = emit_count;
            cap       = 1'b0;
            sh_we     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            cnt        <= '0;
            last_q     <= '0;
            chg_q      <= 1'b0;
            emit_count <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            state      <= state_nxt;
            cur        <= cur_nxt;
            cnt        <= cnt_nxt;
            last_q     <= last_nxt;
            chg_q      <= chg_nxt;
            emit_count <= emit_nxt;
            if (cap) begin
                out_addr_q <= cur;
                out_data_q <= rd_data;
            end
        end
    end

    assign rd_addr          = cur;
    assign out_if.out_valid = (state == HOLD);
    assign out_if.out_addr  = out_addr_q;
    assign out_if.out_data  = out_data_q;
    assign busy             = (state == READ) || (state == HOLD);
    assign done             = (state == DONE);
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected words/done counts queued, monitor compares.
module tb_regfile_dump_reader;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } word_t;

    logic        clk = 1'b0;
    logic        rst, start, abort, changed_only, clear_shadow;
    logic [4:0]  first_addr, last_addr, rd_addr;
    logic [31:0] rd_data;
    logic        busy, done;
    logic [5:0]  emit_count;
    logic [31:0] regs [32];

    word_t      exp_q[$];
    logic [5:0] done_q[$];
    int         total = 0;
    int         bad   = 0;

    regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .first_addr  (first_addr),
        .last_addr   (last_addr),
        .changed_only(changed_only),
        .clear_shadow(clear_shadow),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .out_if      (bus),
        .busy        (busy),
        .done        (done),
        .emit_count  (emit_count)
    );

    always #5 clk = ~clk;

    assign rd_data = (rd_addr == 5'd0) ? 32'd0 : regs[rd_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int unsigned a);
        word_t w;
        w.a = a[4:0];
        w.d = (a == 0) ? 32'd0 : regs[a];
        exp_q.push_back(w);
    endtask

    task automatic push_range(input int unsigned f, input int unsigned l);
        for (int unsigned i = f; i <= l; i++) push_word(i);
    endtask

    task automatic do_start(input int unsigned f, input int unsigned l, input logic chg, input logic clr);
        first_addr   = f[4:0];
        last_addr    = l[4:0];
        changed_only = chg;
        clear_shadow = clr;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        clear_shadow = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int unsigned n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s: got no done pulse expected done within 200 cycles", name);
        end
        tick();
    endtask

    // Monitor: every handshake and every done pulse is checked against the queues.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {27'd0, bus.out_addr, bus.out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                chk("word", {27'd0, bus.out_addr, bus.out_data}, {27'd0, w.a, w.d});
            end
        end
        if (!rst && done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", {58'd0, emit_count}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("emit_count", {58'd0, emit_count}, {58'd0, done_q.pop_front()});
            end
        end
    end

    initial begin
        logic [9:0] vpat;
        logic [9:0] dpat;
        logic [9:0] bpat;
        vpat = 10'b0010101010;  // bit k-1 = out_valid expected k cycles after start edge
        dpat = 10'b0100000000;
        bpat = 10'b0011111111;
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
        regs[0] = 32'hFFFF_FFFF;
        regs[1] = 32'h11; regs[2] = 32'h22; regs[3] = 32'h33;
        rst = 1'b1; start = 1'b0; abort = 1'b0; changed_only = 1'b0; clear_shadow = 1'b0;
        first_addr = '0; last_addr = '0; bus.out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_emit", emit_count, 0);
        chk("rst_addr", {rd_addr, bus.out_addr, bus.out_data}, 0);
        rst = 1'b0;
        tick();

        // 1: basic dump 0..3, exact cycle timing, x0 reads 0
        push_range(0, 3); done_q.push_back(6'd4);
        do_start(0, 3, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("t1_valid_k%0d", k), bus.out_valid, vpat[k-1]);
            chk($sformatf("t1_done_k%0d", k), done, dpat[k-1]);
            chk($sformatf("t1_busy_k%0d", k), busy, bpat[k-1]);
            tick();
        end

        // 2: backpressure on word 1 for 5 cycles
        push_range(0, 3); done_q.push_back(6'd4);
        do_start(0, 3, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            if (k >= 4) begin
                chk("t2_hold_valid", bus.out_valid, 1);
                chk("t2_hold_word", {bus.out_addr, bus.out_data}, {5'd1, 32'h11});
            end
            if (k == 3) bus.out_ready = 1'b0;
            if (k == 8) bus.out_ready = 1'b1;
            tick();
        end
        wait_done("t2_done");

        // 3: changed-only; 0..3 already shadowed by earlier dumps
        push_range(4, 31); done_q.push_back(6'd28);
        do_start(0, 31, 1'b1, 1'b0);
        wait_done("t3a_done");
        regs[5] = 32'hDEAD_BEEF;
        push_word(5); done_q.push_back(6'd1);
        do_start(0, 31, 1'b1, 1'b0);
        wait_done("t3b_done");

        // 4: empty range, then single top register
        done_q.push_back(6'd0);
        do_start(7, 3, 1'b0, 1'b0);
        chk("t4_empty_done", done, 1);
        chk("t4_empty_valid", bus.out_valid, 0);
        tick();
        push_word(31); done_q.push_back(6'd1);
        do_start(31, 31, 1'b0, 1'b0);
        wait_done("t4_single_done");

        // 5: abort in HOLD of word 2
        push_range(0, 1);
        do_start(0, 9, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            if (k == 5) bus.out_ready = 1'b0;
            if (k < 6) tick();
        end
        chk("t5_hold_addr", {bus.out_valid, bus.out_addr}, {1'b1, 5'd2});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_valid", bus.out_valid, 0);
        chk("t5_abort_busy", busy, 0);
        for (int k = 0; k < 4; k++) begin
            chk("t5_no_done", done, 0);
            tick();
        end
        chk("t5_emit_kept", emit_count, 1);
        bus.out_ready = 1'b1;
        push_range(8, 9); done_q.push_back(6'd2);
        do_start(8, 9, 1'b0, 1'b0);
        wait_done("t5_restart_done");

        // 6: start while busy ignored; clear_shadow with start; rst mid-dump
        push_range(0, 3); done_q.push_back(6'd4);
        do_start(0, 3, 1'b0, 1'b0);
        tick(); tick();
        do_start(20, 21, 1'b0, 1'b0);
        wait_done("t6a_done");
        push_range(0, 3); done_q.push_back(6'd4);
        do_start(0, 3, 1'b1, 1'b1);
        wait_done("t6b_done");
        push_word(0);
        do_start(0, 9, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_outs", {bus.out_valid, busy, done, emit_count, rd_addr, bus.out_addr, bus.out_data},
            0);
        rst = 1'b0;
        tick(); tick();

        chk("words_left", exp_q.size(), 0);
        chk("dones_left", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
